// File: rtl/passcode_writer_pkg.sv
// lock_pkg: definitions shared by the lock and the passcode writer.
//   - CODE_W / DEFAULT_CODE : passcode width and the reset value both blocks
//     agree on, so the lock and the writer come out of reset in step.
//   - LED_* : status LED patterns. The writer FSM state encoding is chosen
//     equal to these patterns, so status is simply the state register.
//   - state_e : writer FSM state type.
package lock_pkg;

    localparam int          CODE_W       = 4;
    localparam logic [3:0]  DEFAULT_CODE = 4'b1001;

    localparam logic [3:0]  LED_IDLE     = 4'b0001;
    localparam logic [3:0]  LED_VERIFY   = 4'b0010;
    localparam logic [3:0]  LED_NEW      = 4'b0100;
    localparam logic [3:0]  LED_CONFIRM  = 4'b0110;
    localparam logic [3:0]  LED_COMMIT   = 4'b1000;
    localparam logic [3:0]  LED_FAIL     = 4'b1111;

    typedef enum logic [3:0] {
        ST_IDLE    = LED_IDLE,
        ST_VERIFY  = LED_VERIFY,
        ST_NEW     = LED_NEW,
        ST_CONFIRM = LED_CONFIRM,
        ST_COMMIT  = LED_COMMIT,
        ST_FAIL    = LED_FAIL
    } state_e;

endpackage

// File: rtl/passcode_writer_if.sv
// passcode_writer_if: user-side buttons/switches and the passcode outputs.
//   prog, enter, oops : button levels (debounced externally)
//   login             : switch value
//   passw             : stored passcode to the lock compare input
//   passw_we          : one-cycle strobe when passw takes a new value
//   busy, status      : FSM activity and LED pattern
// master = board/stimulus side, slave = passcode_writer.
interface passcode_writer_if #(
    parameter int WIDTH = 4
);
    logic             prog;
    logic             enter;
    logic             oops;
    logic [WIDTH-1:0] login;
    logic [WIDTH-1:0] passw;
    logic             passw_we;
    logic             busy;
    logic [3:0]       status;

    modport master (
        output prog, enter, oops, login,
        input  passw, passw_we, busy, status
    );

    modport slave (
        input  prog, enter, oops, login,
        output passw, passw_we, busy, status
    );
endinterface

// File: rtl/passcode_writer_btn_pulse.sv
// btn_pulse: turns a button level into a single-cycle pulse on its rising edge.
//   clk, rst_n : clock, asynchronous active-low reset
//   btn_i      : button level
//   pulse_o    : high for one cycle when the (optionally synchronised) level rises
// Macro PASSCODE_BTN_SYNC_EN inserts a 2-flop synchroniser ahead of the edge
// detector (+2 cycles of latency). All flops reset to 0, so a button already
// held at reset release yields one pulse.
module btn_pulse (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic pulse_o
);
    logic level;
    logic prev_q;

`ifdef PASSCODE_BTN_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= 2'b00;
        else        sync_q <= {sync_q[0], btn_i};
    end

    assign level = sync_q[1];
`else
    assign level = btn_i;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) prev_q <= 1'b0;
        else        prev_q <= level;
    end

    assign pulse_o = level & ~prev_q;
endmodule

// File: rtl/passcode_writer.sv
// passcode_writer: programs the passcode the lock compares against.
// Sequence: prog -> prove current code -> enter new code -> confirm it.
//   clk     : system clock
//   reset_n : asynchronous active-low reset
//   bus     : passcode_writer_if.slave (buttons, switches, passw, passw_we,
//             busy, status)
// Parameters: WIDTH, DEFAULT_CODE, MAX_TRIES (1..3), FAIL_HOLD (cycles).
// Optional macro PASSCODE_BTN_SYNC_EN adds button synchronisers (in btn_pulse).
module passcode_writer
    import lock_pkg::*;
#(
    parameter int               WIDTH        = 4,
    parameter logic [WIDTH-1:0] DEFAULT_CODE = lock_pkg::DEFAULT_CODE,
    parameter int               MAX_TRIES    = 2,
    parameter int               FAIL_HOLD    = 100_000_000
) (
    input  logic              clk,
    input  logic              reset_n,
    passcode_writer_if.slave  bus
);
    localparam int         HOLD_W    = (FAIL_HOLD > 1) ? $clog2(FAIL_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(FAIL_HOLD - 1);
    localparam logic [1:0] TRIES_MAX = 2'(MAX_TRIES);

    // Button pulses: index 0 = prog, 1 = enter, 2 = oops.
    logic [2:0] btn_lvl;
    logic [2:0] btn_pls;
    logic       prog_p, enter_p, oops_p;

    assign btn_lvl = {bus.oops, bus.enter, bus.prog};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_btn
            btn_pulse u_btn (
                .clk     (clk),
                .rst_n   (reset_n),
                .btn_i   (btn_lvl[gi]),
                .pulse_o (btn_pls[gi])
            );
        end
    endgenerate

    assign prog_p  = btn_pls[0];
    assign enter_p = btn_pls[1];
    assign oops_p  = btn_pls[2];

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  passw_q, passw_d;
    logic [WIDTH-1:0]  cand_q, cand_d;
    logic [1:0]        tries_q, tries_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              we_q, we_d;
    logic [2:0]        tries_inc;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            passw_q <= DEFAULT_CODE;
            cand_q  <= '0;
            tries_q <= 2'd0;
            hold_q  <= '0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            passw_q <= passw_d;
            cand_q  <= cand_d;
            tries_q <= tries_d;
            hold_q  <= hold_d;
            we_q    <= we_d;
        end
    end

    // 3 bits so the comparison against MAX_TRIES cannot wrap.
    assign tries_inc = {1'b0, tries_q} + 3'd1;

    always_comb begin
        state_d = state_q;
        passw_d = passw_q;
        cand_d  = cand_q;
        tries_d = tries_q;
        hold_d  = hold_q;
        we_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // prog wins over a simultaneous enter; enter/oops alone do nothing.
                if (prog_p) begin
                    state_d = ST_VERIFY;
                    tries_d = 2'd0;
                end
            end
            ST_VERIFY: begin
                if (oops_p) begin
                    state_d = ST_IDLE;
                    tries_d = 2'd0;
                end else if (enter_p) begin
                    if (bus.login == passw_q) begin
                        state_d = ST_NEW;
                    end else if (tries_inc >= {1'b0, TRIES_MAX}) begin
                        state_d = ST_FAIL;
                        tries_d = TRIES_MAX;
                    end else begin
                        tries_d = tries_inc[1:0];
                    end
                end
            end
            ST_NEW: begin
                if (oops_p) begin
                    state_d = ST_IDLE;
                    tries_d = 2'd0;
                end else if (enter_p) begin
                    cand_d  = bus.login;
                    state_d = ST_CONFIRM;
                end
            end
            ST_CONFIRM: begin
                if (oops_p) begin
                    state_d = ST_IDLE;
                    tries_d = 2'd0;
                end else if (enter_p) begin
                    state_d = (bus.login == cand_q) ? ST_COMMIT : ST_NEW;
                end
            end
            ST_COMMIT: begin
                // passw and its strobe are loaded on the same edge, so the
                // strobe is high in the first cycle the new code is visible.
                passw_d = cand_q;
                we_d    = 1'b1;
                state_d = ST_IDLE;
            end
            ST_FAIL: begin
                if (hold_q == HOLD_LAST) begin
                    hold_d  = '0;
                    state_d = ST_IDLE;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.passw    = passw_q;
    assign bus.passw_we = we_q;
    assign bus.busy     = (state_q != ST_IDLE);
    assign bus.status   = state_q;
endmodule

// File: tb/tb_passcode_writer.sv
module tb_passcode_writer;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    logic [3:0] cur_code;
    logic [3:0] exp_q[$];

    always #5 clk = ~clk;

    passcode_writer_if #(.WIDTH(4)) bus ();

    passcode_writer #(
        .WIDTH        (4),
        .DEFAULT_CODE (4'b1001),
        .MAX_TRIES    (2),
        .FAIL_HOLD    (4)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Scoreboard: every passw_we strobe must match the oldest expected commit.
    always @(negedge clk) begin
        if (bus.passw_we === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL commit_unexpected got passw=%b, expected no strobe", bus.passw);
            end else begin
                logic [3:0] e;
                e = exp_q.pop_front();
                if (bus.passw !== e) begin
                    errors++;
                    $display("FAIL commit_value got passw=%b expected %b", bus.passw, e);
                end else begin
                    $display("commit passw=%b", bus.passw);
                end
            end
        end
    end

    task automatic press(input logic p, input logic e, input logic o, input logic [3:0] v);
        @(posedge clk); #1;
        bus.login = v; bus.prog = p; bus.enter = e; bus.oops = o;
        @(posedge clk); #1;
        bus.prog = 1'b0; bus.enter = 1'b0; bus.oops = 1'b0;
    endtask

    task automatic test_reset();
        bus.prog = 0; bus.enter = 0; bus.oops = 0; bus.login = 4'b0000;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (bus.status !== 4'b0001) begin errors++; $display("FAIL reset_status got %b expected 0001", bus.status); end
        @(posedge clk); #1 reset_n = 1'b1;
        @(negedge clk);
        checks++; if (bus.passw !== 4'b1001) begin errors++; $display("FAIL reset_passw got %b expected 1001", bus.passw); end
        checks++; if (bus.status !== 4'b0001) begin errors++; $display("FAIL reset_status2 got %b expected 0001", bus.status); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b expected 0", bus.busy); end
        checks++; if (bus.passw_we !== 1'b0) begin errors++; $display("FAIL reset_we got %b expected 0", bus.passw_we); end
        cur_code = 4'b1001;
        $display("reset done passw=%b", bus.passw);
    endtask

    task automatic test_nominal();
        press(1, 0, 0, 4'b0000); @(negedge clk);
        checks++; if (bus.status !== 4'b0010) begin errors++; $display("FAIL nom_verify got %b expected 0010", bus.status); end
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL nom_busy got %b expected 1", bus.busy); end
        press(0, 1, 0, cur_code); @(negedge clk);
        checks++; if (bus.status !== 4'b0100) begin errors++; $display("FAIL nom_new got %b expected 0100", bus.status); end
        press(0, 1, 0, 4'b0110); @(negedge clk);
        checks++; if (bus.status !== 4'b0110) begin errors++; $display("FAIL nom_confirm got %b expected 0110", bus.status); end
        exp_q.push_back(4'b0110);
        press(0, 1, 0, 4'b0110); @(negedge clk);
        checks++; if (bus.status !== 4'b1000) begin errors++; $display("FAIL nom_commit got %b expected 1000", bus.status); end
        checks++; if (bus.passw !== cur_code) begin errors++; $display("FAIL nom_passw_early got %b expected %b", bus.passw, cur_code); end
        @(negedge clk);
        checks++; if (bus.status !== 4'b0001) begin errors++; $display("FAIL nom_idle got %b expected 0001", bus.status); end
        checks++; if (bus.passw !== 4'b0110) begin errors++; $display("FAIL nom_passw got %b expected 0110", bus.passw); end
        @(negedge clk);
        checks++; if (bus.passw_we !== 1'b0) begin errors++; $display("FAIL nom_we_width got %b expected 0", bus.passw_we); end
        cur_code = 4'b0110;
        $display("nominal change to %b", cur_code);
    endtask

    task automatic test_lockout();
        press(1, 0, 0, 4'b0000);
        press(0, 1, 0, 4'b0000); @(negedge clk);
        checks++; if (bus.status !== 4'b0010) begin errors++; $display("FAIL lock_try1 got %b expected 0010", bus.status); end
        press(0, 1, 0, 4'b0000);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++; if (bus.status !== 4'b1111) begin errors++; $display("FAIL lock_hold%0d got %b expected 1111", i, bus.status); end
            if (i == 1) begin bus.login = cur_code; bus.enter = 1'b1; bus.oops = 1'b1; end
            if (i == 2) begin bus.enter = 1'b0; bus.oops = 1'b0; end
        end
        @(negedge clk);
        checks++; if (bus.status !== 4'b0001) begin errors++; $display("FAIL lock_exit got %b expected 0001", bus.status); end
        checks++; if (bus.passw !== cur_code) begin errors++; $display("FAIL lock_passw got %b expected %b", bus.passw, cur_code); end
        // tries restart at 0 on the next attempt: one miss keeps VERIFY
        press(1, 0, 0, 4'b0000);
        press(0, 1, 0, 4'b1111); @(negedge clk);
        checks++; if (bus.status !== 4'b0010) begin errors++; $display("FAIL lock_retry got %b expected 0010", bus.status); end
        press(0, 0, 1, 4'b0000); @(negedge clk);
        checks++; if (bus.status !== 4'b0001) begin errors++; $display("FAIL lock_oops got %b expected 0001", bus.status); end
        $display("lockout sequence done");
    endtask

    task automatic test_mismatch();
        press(1, 0, 0, 4'b0000);
        press(0, 1, 0, cur_code);
        press(0, 1, 0, 4'b0011);
        press(0, 1, 0, 4'b0101); @(negedge clk);
        checks++; if (bus.status !== 4'b0100) begin errors++; $display("FAIL mis_back_new got %b expected 0100", bus.status); end
        checks++; if (bus.passw !== cur_code) begin errors++; $display("FAIL mis_passw got %b expected %b", bus.passw, cur_code); end
        press(0, 1, 0, 4'b0101);
        exp_q.push_back(4'b0101);
        press(0, 1, 0, 4'b0101);
        repeat (2) @(negedge clk);
        checks++; if (bus.passw !== 4'b0101) begin errors++; $display("FAIL mis_commit got %b expected 0101", bus.passw); end
        cur_code = 4'b0101;
        $display("mismatch then commit %b", cur_code);
    endtask

    task automatic test_cancel();
        press(1, 0, 0, 4'b0000);
        press(0, 1, 0, cur_code);
        press(0, 1, 0, 4'b1100); @(negedge clk);
        checks++; if (bus.status !== 4'b0110) begin errors++; $display("FAIL can_confirm got %b expected 0110", bus.status); end
        press(0, 1, 1, 4'b1100); @(negedge clk);
        checks++; if (bus.status !== 4'b0001) begin errors++; $display("FAIL can_idle got %b expected 0001", bus.status); end
        checks++; if (bus.passw !== cur_code) begin errors++; $display("FAIL can_passw got %b expected %b", bus.passw, cur_code); end
        // prog + enter together in IDLE acts as prog only
        press(1, 1, 0, cur_code); @(negedge clk);
        checks++; if (bus.status !== 4'b0010) begin errors++; $display("FAIL sim_prog_enter got %b expected 0010", bus.status); end
        // prog outside IDLE is ignored
        press(1, 0, 0, 4'b0000); @(negedge clk);
        checks++; if (bus.status !== 4'b0010) begin errors++; $display("FAIL sim_prog_verify got %b expected 0010", bus.status); end
        press(0, 0, 1, 4'b0000);
        $display("cancel/simultaneity done");
    endtask

    task automatic test_hold();
        press(1, 0, 0, 4'b0000);
        @(posedge clk); #1 bus.login = cur_code; bus.enter = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i > 0) begin
                checks++; if (bus.status !== 4'b0100) begin errors++; $display("FAIL hold_cycle%0d got %b expected 0100", i, bus.status); end
            end
        end
        bus.enter = 1'b0;
        press(0, 0, 1, 4'b0000); @(negedge clk);
        checks++; if (bus.status !== 4'b0001) begin errors++; $display("FAIL hold_oops got %b expected 0001", bus.status); end
        $display("held enter gave one action");
    endtask

    task automatic test_async_reset();
        press(1, 0, 0, 4'b0000);
        press(0, 1, 0, cur_code);
        press(0, 1, 0, 4'b0110);
        exp_q.push_back(4'b0110);
        press(0, 1, 0, 4'b0110);
        repeat (2) @(negedge clk);
        checks++; if (bus.passw !== 4'b0110) begin errors++; $display("FAIL ar_commit got %b expected 0110", bus.passw); end
        press(1, 0, 0, 4'b0000);
        press(0, 1, 0, 4'b0110);
        press(0, 1, 0, 4'b0011); @(negedge clk);
        checks++; if (bus.status !== 4'b0110) begin errors++; $display("FAIL ar_confirm got %b expected 0110", bus.status); end
        @(posedge clk); #2 reset_n = 1'b0;
        #1;
        checks++; if (bus.status !== 4'b0001) begin errors++; $display("FAIL ar_status got %b expected 0001", bus.status); end
        checks++; if (bus.passw !== 4'b1001) begin errors++; $display("FAIL ar_passw got %b expected 1001", bus.passw); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL ar_busy got %b expected 0", bus.busy); end
        @(posedge clk); #1 reset_n = 1'b1;
        @(negedge clk);
        checks++; if (bus.status !== 4'b0001) begin errors++; $display("FAIL ar_after got %b expected 0001", bus.status); end
        cur_code = 4'b1001;
        $display("async reset restored %b", bus.passw);
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_lockout();
        test_mismatch();
        test_cancel();
        test_hold();
        test_async_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_commits got %0d pending expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/passcode_writer.md
Name: passcode_writer

Overview:
- Programs the lock's stored passcode: the write side of the code that the lock FSM compares against.
- User presses prog, proves knowledge of the current code, enters a new code, then confirms it on the 4 switches.
- A matching confirmation commits the new code to the `passw` output register, which drives the lock's compare input.
- Sits beside the lock on the Arty board, sharing the same switches and buttons.

Parameters:
- WIDTH, 4, passcode width in bits (matches switch count)
- DEFAULT_CODE, 4'b1001, value of passw after reset
- MAX_TRIES, 2, wrong current-code entries allowed before lockout (1..3)
- FAIL_HOLD, 100_000_000, lockout duration in clk cycles (1 s at 100 MHz)

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- prog  in  1  button: start programming sequence (level, debounced externally)
- enter  in  1  button: submit switch value (level)
- oops  in  1  button: cancel sequence (level)
- login  in  WIDTH  switch value
- passw  out  WIDTH  stored passcode, fed to lock compare input
- passw_we  out  1  one-cycle pulse in the cycle passw takes a new value
- busy  out  1  high in any state other than IDLE
- status  out  4  state indication for LEDs

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, passw=DEFAULT_CODE, cand=0, tries=0, hold counter=0
  - passw_we=0, busy=0, status=4'b0001
- Buttons:
  - Each button passes through a rising-edge detector (registered previous sample).
  - Pulse = level & ~prev. FSM acts only on pulses, so holding a button produces exactly one action.
  - Previous-sample registers reset to 0. A button held through reset release therefore produces one pulse in the first cycle.
- Latency: state changes on the clk edge ending the cycle in which the pulse is high, i.e. 1 cycle after the button's first high sample.
- States and status encoding:
  - IDLE 0001
  - VERIFY 0010
  - NEW 0100
  - CONFIRM 0110
  - COMMIT 1000
  - FAIL 1111
- Transitions:
  - IDLE: prog pulse -> VERIFY, tries<=0. enter/oops ignored.
  - VERIFY, enter pulse:
    - login==passw -> NEW.
    - Otherwise tries<=tries+1. If tries+1==MAX_TRIES -> FAIL, else stay in VERIFY.
  - NEW: enter pulse -> cand<=login, go to CONFIRM. Any value is accepted, including the current passw.
  - CONFIRM, enter pulse:
    - login==cand -> COMMIT.
    - Otherwise -> NEW; cand keeps its old value until overwritten.
  - COMMIT: single cycle. passw<=cand, passw_we=1, -> IDLE.
  - FAIL: hold counter counts 0..FAIL_HOLD-1, then -> IDLE and counter clears. All buttons are ignored, including oops.
- oops pulse in VERIFY/NEW/CONFIRM -> IDLE next cycle. passw is unchanged, tries are cleared.
- Simultaneous pulses:
  - oops beats enter.
  - prog is ignored outside IDLE.
  - prog and enter together in IDLE: prog only.
- passw changes only in the COMMIT cycle. passw_we is registered and high for exactly that one cycle.
- Comparisons are unsigned WIDTH-bit equality. tries is 2 bits wide, and its count saturates at MAX_TRIES.
- Async reset mid-sequence aborts the sequence and restores DEFAULT_CODE; a committed code is not retained.

Optional Feature:
- Macro: PASSCODE_BTN_SYNC_EN.
- Defined: each of prog/enter/oops passes through a 2-flop synchronizer (reset to 0) ahead of its edge detector. This adds 2 cycles of latency, so an action lands 3 cycles after the button rises.
- Undefined: buttons go straight to the edge detectors, giving the 1-cycle latency stated above.

Decomposition:
- Shared package (lock_pkg):
  - state encoding localparams for this FSM
  - DEFAULT_CODE value, shared with the lock so both reset to the same code
  - status LED patterns
- One sub-module: btn_pulse. It holds the optional synchronizer plus the rising-edge detector, is parameter-free and 1-bit wide, and is instantiated 3 times.

Test Plan:
- Reset -> passw=4'b1001, status=0001, busy=0, passw_we=0.
- Nominal change:
  - Stimulus: prog; login=1001 + enter; login=0110 + enter; login=0110 + enter.
  - Response: status walks 0010, 0100, 0110, 1000, 0001. passw_we pulses for 1 cycle and passw=0110 thereafter.
- Lockout (FAIL_HOLD=4, MAX_TRIES=2):
  - Stimulus: prog; login=0000 + enter twice.
  - Response: FAIL status=1111 for exactly 4 cycles, then IDLE. passw stays 1001. An enter during FAIL has no effect.
- Confirm mismatch:
  - Stimulus: prog; 1001 + enter; 0011 + enter; 0101 + enter.
  - Response: back in NEW (0100), passw unchanged. Then 0101 + enter and 0101 + enter commits 0101.
- Cancel and simultaneity:
  - In CONFIRM, press oops and enter in the same cycle with login==cand.
  - Response: -> IDLE, no passw_we.
  - Holding enter high for 10 cycles yields a single action.
- Async reset mid-sequence: assert reset_n=0 while in CONFIRM, after a previous commit of 0110 -> immediate IDLE and passw=1001.
